mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 120 ++++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request/response handshake and a single-port data memory.
// One request in flight; every output is a register.
module mem_access_unit #(
    parameter int unsigned DEPTH = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_store,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_rdata,
    output logic       resp_err,
    output logic       mem_write,
    output logic       mem_read,
    output logic [5:0] endereco,
    output logic [7:0] valor_escrita,
    input  logic [7:0] valor_saida,
    output logic [7:0] load_count,
    output logic [7:0] store_count
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e     state_q, state_d;
    logic       store_q, store_d;
    logic       req_ready_d, resp_valid_d, resp_err_d, mem_write_d, mem_read_d;
    logic [7:0] resp_rdata_d, valor_escrita_d, load_count_d, store_count_d;
    logic [5:0] endereco_d;
    logic       req_fire, addr_err;

    assign req_fire = req_valid && req_ready;
    assign addr_err = 32'(req_addr) >= DEPTH;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            store_q       <= 1'b0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= 8'h00;
            mem_write     <= 1'b0;
            mem_read      <= 1'b0;
            endereco      <= 6'd0;
            valor_escrita <= 8'h00;
            load_count    <= 8'h00;
            store_count   <= 8'h00;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            req_ready     <= req_ready_d;
            resp_valid    <= resp_valid_d;
            resp_err      <= resp_err_d;
            resp_rdata    <= resp_rdata_d;
            mem_write     <= mem_write_d;
            mem_read      <= mem_read_d;
            endereco      <= endereco_d;
            valor_escrita <= valor_escrita_d;
            load_count    <= load_count_d;
            store_count   <= store_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_fire) state_d = addr_err ? StResp : StIssue;
            StIssue: state_d = store_q ? StResp : StWait;
            StWait:  state_d = StResp;
            StResp:  if (resp_ready) state_d = StIdle;
        endcase
    end

    // Outputs are computed from the transition being taken so they register with the state.
    always_comb begin
        store_d         = store_q;
        req_ready_d     = (state_d == StIdle);
        resp_valid_d    = (state_d == StResp);
        resp_err_d      = resp_err;
        resp_rdata_d    = resp_rdata;
        mem_write_d     = 1'b0;
        mem_read_d      = 1'b0;
        endereco_d      = endereco;
        valor_escrita_d = valor_escrita;
        load_count_d    = load_count;
        store_count_d   = store_count;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    store_d         = req_store;
                    endereco_d      = req_addr;
                    valor_escrita_d = req_wdata;
                    resp_rdata_d    = 8'h00;
                    resp_err_d      = addr_err;
                    mem_write_d     = !addr_err && req_store;
                    mem_read_d      = !addr_err && !req_store;
                end
            end
            StIssue: begin
            end
            StWait: begin
                resp_rdata_d = valor_saida;
            end
            StResp: begin
                if (resp_ready && !resp_err) begin
                    if (store_q) begin
                        if (store_count != 8'hFF) store_count_d = store_count + 8'd1;
                    end else begin
                        if (load_count != 8'hFF) load_count_d = load_count + 8'd1;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data memory and a response scoreboard.
module tb_mem_access_unit;

    localparam int unsigned DEPTH = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_store = 1'b0;
    logic [5:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [7:0] resp_rdata;
    logic       resp_err;
    logic       mem_write;
    logic       mem_read;
    logic [5:0] endereco;
    logic [7:0] valor_escrita;
    logic [7:0] valor_saida = '0;
    logic [7:0] load_count;
    logic [7:0] store_count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       err;
        logic       store;
        logic [7:0] rdata;
        logic [3:0] lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model[64];
    logic [7:0] mem[64] = '{default: 8'h00};
    int         exp_loads = 0;
    int         exp_stores = 0;

    mem_access_unit #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .endereco     (endereco),
        .valor_escrita(valor_escrita),
        .valor_saida  (valor_saida),
        .load_count   (load_count),
        .store_count  (store_count)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears one cycle after the edge sampling mem_read.
    always @(posedge clk) begin
        if (mem_write) mem[endereco] <= valor_escrita;
        if (mem_read) valor_saida <= mem[endereco];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_endereco", endereco, 0);
        chk("rst_valor_escrita", valor_escrita, 0);
        chk("rst_load_count", load_count, 0);
        chk("rst_store_count", store_count, 0);
    endtask

    task automatic do_req(input logic st, input logic [5:0] addr, input logic [7:0] wd,
                          input int hold);
        exp_t e, got;
        logic legal;
        int   n, lat, wr, rd;
        legal   = addr < DEPTH;
        e.err   = !legal;
        e.store = st;
        e.rdata = (!legal || st) ? 8'h00 : model[addr];
        e.lat   = !legal ? 4'd1 : (st ? 4'd2 : 4'd3);
        if (legal && st) model[addr] = wd;
        sb.push_back(e);

        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_store = st;
        req_addr  = addr;
        req_wdata = wd;
        lat = 0; wr = 0; rd = 0;
        do begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            lat++;
            if (mem_write) begin
                wr++;
                chk("wr_addr", endereco, addr);
                chk("wr_data", valor_escrita, wd);
            end
            if (mem_read) begin
                rd++;
                chk("rd_addr", endereco, addr);
            end
        end while (!resp_valid && lat < 8);

        got = sb.pop_front();
        chk("resp_valid", resp_valid, 1);
        chk("latency", lat, got.lat);
        chk("resp_err", resp_err, got.err);
        chk("resp_rdata", resp_rdata, got.rdata);
        chk("wr_pulses", wr, legal && st);
        chk("rd_pulses", rd, legal && !st);
        chk("req_ready_busy", req_ready, 0);

        // A stray request during backpressure must be ignored.
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_resp_valid", resp_valid, 1);
            chk("hold_resp_rdata", resp_rdata, got.rdata);
            chk("hold_resp_err", resp_err, got.err);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_strobes", {mem_read, mem_write}, 0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        if (legal) begin
            if (st) exp_stores = (exp_stores < 255) ? exp_stores + 1 : 255;
            else    exp_loads  = (exp_loads  < 255) ? exp_loads  + 1 : 255;
            chk("endereco_hold", endereco, addr);
        end
        chk("done_resp_valid", resp_valid, 0);
        chk("done_req_ready", req_ready, 1);
        chk("load_count", load_count, exp_loads);
        chk("store_count", store_count, exp_stores);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b1, 6'd5, 8'hA7, 0);
        do_req(1'b0, 6'd5, 8'h00, 0);
        do_req(1'b0, 6'd50, 8'h00, 0);
        do_req(1'b1, 6'd63, 8'h3C, 0);
        do_req(1'b0, 6'd5, 8'h00, 4);

        // Reset while the load strobe is high aborts it with no response.
        req_valid = 1'b1;
        req_store = 1'b0;
        req_addr  = 6'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_mem_read", mem_read, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_reset_state();
        exp_loads  = 0;
        exp_stores = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_resp", resp_valid, 0);
            chk("abort_no_read", mem_read, 0);
        end
        do_req(1'b0, 6'd0, 8'h00, 0);

        do_req(1'b1, 6'd49, 8'h5A, 1);
        do_req(1'b0, 6'd49, 8'h00, 0);
        do_req(1'b1, 6'd0, 8'hFF, 0);
        do_req(1'b0, 6'd0, 8'h00, 2);
        do_req(1'b0, 6'd49, 8'h00, 0);

        for (int i = 0; i < 260; i++) do_req(1'b1, 6'(i % 50), 8'(i), 0);
        chk("store_saturated", store_count, 255);
        chk("load_after_sat", load_count, exp_loads);
        do_req(1'b0, 6'd9, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
